// File: rtl/term_sm_pkg.sv
// rtl/term_sm_pkg.sv - shared mode encoding and config-chain constants for the loopback switch matrix
package term_sm_pkg;

    typedef enum logic [1:0] {
        TM_REVERSE  = 2'b00,
        TM_STRAIGHT = 2'b01,
        TM_TIE0     = 2'b10,
        TM_TIE1     = 2'b11
    } term_mode_e;

    localparam int NUM_GROUPS = 4;
    localparam int MODE_W     = 2;
    localparam int CFG_BITS   = NUM_GROUPS * MODE_W;

    localparam int G_N1    = 0;
    localparam int G_N2MID = 1;
    localparam int G_N2END = 2;
    localparam int G_N4    = 3;

endpackage

// File: rtl/term_sm_group.sv
// rtl/term_sm_group.sv - one wire group's mode-selected mapping; output register under TERM_LOOPBACK_PIPE_EN
module term_sm_group
    import term_sm_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  term_mode_e   mode_i,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);

    logic [W-1:0] map_d;

    always_comb begin
        map_d = '0;
        case (mode_i)
            TM_REVERSE: begin
                for (int i = 0; i < W; i++) begin
                    map_d[i] = in_i[W-1-i];
                end
            end
            TM_STRAIGHT: map_d = in_i;
            TM_TIE0:     map_d = '0;
            TM_TIE1:     map_d = '1;
            default:     map_d = '0;
        endcase
    end

`ifdef TERM_LOOPBACK_PIPE_EN
    logic [W-1:0] out_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q <= '0;
        end else begin
            out_q <= map_d;
        end
    end

    assign out_o = out_q;
`else
    // Clock and reset only matter for the pipelined build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign out_o = map_d;
`endif

endmodule

// File: rtl/term_loopback_switch_matrix.sv
// rtl/term_loopback_switch_matrix.sv - north-to-south loopback with serial shadow/commit mode chain; TERM_LOOPBACK_PIPE_EN registers S* outputs
module term_loopback_switch_matrix
    import term_sm_pkg::*;
#(
    parameter int          N1W        = 4,
    parameter int          N2W        = 8,
    parameter int          N4W        = 16,
    parameter logic [1:0]  RESET_MODE = 2'b00
) (
    input  logic           UserCLK,
    input  logic           RESET,
    input  logic [N1W-1:0] N1END,
    input  logic [N2W-1:0] N2MID,
    input  logic [N2W-1:0] N2END,
    input  logic [N4W-1:0] N4END,
    output logic [N1W-1:0] S1BEG,
    output logic [N2W-1:0] S2BEG,
    output logic [N2W-1:0] S2BEGb,
    output logic [N4W-1:0] S4BEG,
    input  logic           cfg_shift_en,
    input  logic           cfg_data_in,
    output logic           cfg_data_out,
    input  logic           cfg_commit,
    output logic           cfg_ack,
    output logic           cfg_err
);

    localparam int                CNT_W    = $clog2(CFG_BITS + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(CFG_BITS + 1);
    localparam logic [CFG_BITS-1:0] CFG_RESET = {NUM_GROUPS{RESET_MODE}};

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;

    // Commit takes priority over shift and judges the pre-edge bit count.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        if (cfg_commit) begin
            cnt_d = '0;
            if (cnt_q == CNT_FULL) begin
                active_d = shadow_q;
                ack_d    = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (cfg_shift_en) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], cfg_data_in};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            shadow_q <= CFG_RESET;
            active_q <= CFG_RESET;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign cfg_data_out = shadow_q[CFG_BITS-1];
    assign cfg_ack      = ack_q;
    assign cfg_err      = err_q;

    term_sm_group #(.W(N1W)) u_g_n1 (
        .clk_i  (UserCLK),
        .rst_i  (RESET),
        .mode_i (term_mode_e'(active_q[G_N1*MODE_W +: MODE_W])),
        .in_i   (N1END),
        .out_o  (S1BEG)
    );

    term_sm_group #(.W(N2W)) u_g_n2mid (
        .clk_i  (UserCLK),
        .rst_i  (RESET),
        .mode_i (term_mode_e'(active_q[G_N2MID*MODE_W +: MODE_W])),
        .in_i   (N2MID),
        .out_o  (S2BEG)
    );

    term_sm_group #(.W(N2W)) u_g_n2end (
        .clk_i  (UserCLK),
        .rst_i  (RESET),
        .mode_i (term_mode_e'(active_q[G_N2END*MODE_W +: MODE_W])),
        .in_i   (N2END),
        .out_o  (S2BEGb)
    );

    term_sm_group #(.W(N4W)) u_g_n4 (
        .clk_i  (UserCLK),
        .rst_i  (RESET),
        .mode_i (term_mode_e'(active_q[G_N4*MODE_W +: MODE_W])),
        .in_i   (N4END),
        .out_o  (S4BEG)
    );

endmodule
